// File: rtl/window_3x3_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3_generator_pkg
// Description : Shared image geometry defaults and sizing helper for the
//               3x3 window generator and the filter blocks it feeds.
// Revision    : 1.0  initial release
// ============================================================================
package window_3x3_generator_pkg;

    // Frame geometry shared with the downstream 3x3 filter bank
    localparam int c_default_data_w     = 8;
    localparam int c_default_img_width  = 320;
    localparam int c_default_img_height = 240;

    // Counter/pointer width for a modulus of n; never narrower than one bit
    function automatic int f_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : window_3x3_generator_pkg
`default_nettype wire

// File: rtl/window_3x3_generator_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3_generator_line_buffer
// Description : Enabled delay line of DEPTH samples built as a circular RAM.
//               dout is the sample written DEPTH enabled cycles earlier;
//               it is read before the same slot is overwritten.
// Revision    : 1.0  initial release
// ============================================================================
module window_3x3_generator_line_buffer
    import window_3x3_generator_pkg::*;
#(
    parameter int DEPTH  = c_default_img_width,
    parameter int DATA_W = c_default_data_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int                  c_addr_w = f_addr_w(DEPTH);
    localparam logic [c_addr_w-1:0] c_last   = c_addr_w'(DEPTH - 1);

    logic [c_addr_w-1:0] r_ptr;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    // Circular pointer advances once per enabled sample and wraps at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
        end
    end

    // Storage needs no reset: stale contents are never emitted by the top
    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[r_ptr] <= din;
        end
    end

    assign dout = r_mem[r_ptr];

endmodule : window_3x3_generator_line_buffer
`default_nettype wire

// File: rtl/window_3x3_generator.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3_generator
// Description : Builds a registered row-major 3x3 neighbourhood from a raster
//               pixel stream using two line buffers; one window per interior
//               pixel position, with in_sof resynchronising to (0,0).
// Revision    : 1.0  initial release
// ============================================================================
module window_3x3_generator
    import window_3x3_generator_pkg::*;
#(
    parameter int DATA_W     = c_default_data_w,
    parameter int IMG_WIDTH  = c_default_img_width,
    parameter int IMG_HEIGHT = c_default_img_height
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
    output logic              out_last,
    output logic [DATA_W-1:0] win1,
    output logic [DATA_W-1:0] win2,
    output logic [DATA_W-1:0] win3,
    output logic [DATA_W-1:0] win4,
    output logic [DATA_W-1:0] win5,
    output logic [DATA_W-1:0] win6,
    output logic [DATA_W-1:0] win7,
    output logic [DATA_W-1:0] win8,
    output logic [DATA_W-1:0] win9
);

    localparam int                 c_col_w   = f_addr_w(IMG_WIDTH);
    localparam int                 c_row_w   = f_addr_w(IMG_HEIGHT);
    localparam logic [c_col_w-1:0] c_col_max = c_col_w'(IMG_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_max = c_row_w'(IMG_HEIGHT - 1);
    localparam logic [c_col_w-1:0] c_col_two = c_col_w'(2);
    localparam logic [c_row_w-1:0] c_row_two = c_row_w'(2);

    // Raster position of the next pixel
    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;

    // Two previous columns of the window: [0..1] top, [2..3] middle, [4..5] bottom
    logic [DATA_W-1:0]  r_hist [6];

    // Output window and qualifiers
    logic [DATA_W-1:0]  r_win [9];
    logic               r_out_valid;
    logic               r_out_last;

    logic [DATA_W-1:0]  w_lb0_out;
    logic [DATA_W-1:0]  w_lb1_out;
    logic [c_col_w-1:0] w_col;
    logic [c_row_w-1:0] w_row;
    logic               w_win_valid;
    logic               w_win_last;
    logic [DATA_W-1:0]  w_next [9];

    // LB0 delays the input by one line, LB1 delays LB0 by another line
    window_3x3_generator_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W)
    ) u_lb0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (in_valid),
        .din    (in_pixel),
        .dout   (w_lb0_out)
    );

    window_3x3_generator_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W)
    ) u_lb1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (in_valid),
        .din    (w_lb0_out),
        .dout   (w_lb1_out)
    );

    // Effective position of the current pixel (sof forces the frame origin)
    // and the window qualifiers derived from it
    always_comb begin
        w_col       = in_sof ? '0 : r_col;
        w_row       = in_sof ? '0 : r_row;
        w_win_valid = (w_row >= c_row_two) && (w_col >= c_col_two);
        w_win_last  = (w_row == c_row_max) && (w_col == c_col_max);
    end

    // Window as it stands once the current pixel is shifted in
    always_comb begin
        w_next[0] = r_hist[0];
        w_next[1] = r_hist[1];
        w_next[2] = w_lb1_out;
        w_next[3] = r_hist[2];
        w_next[4] = r_hist[3];
        w_next[5] = w_lb0_out;
        w_next[6] = r_hist[4];
        w_next[7] = r_hist[5];
        w_next[8] = in_pixel;
    end

    // Column/row counters; col wraps into row, row wraps into the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_col == c_col_max) begin
                r_col <= '0;
                r_row <= (w_row == c_row_max) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    // Shift each window row left by one on every accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                r_hist[i] <= '0;
            end
        end else if (in_valid) begin
            r_hist[0] <= w_next[1];
            r_hist[1] <= w_next[2];
            r_hist[2] <= w_next[4];
            r_hist[3] <= w_next[5];
            r_hist[4] <= w_next[7];
            r_hist[5] <= w_next[8];
        end
    end

    // Pulse qualifiers every cycle; they are high only for accepted interior pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= in_valid && w_win_valid;
            r_out_last  <= in_valid && w_win_valid && w_win_last;
        end
    end

    // Output window loads only for valid windows and holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else if (in_valid && w_win_valid) begin
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= w_next[i];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign win1      = r_win[0];
    assign win2      = r_win[1];
    assign win3      = r_win[2];
    assign win4      = r_win[3];
    assign win5      = r_win[4];
    assign win6      = r_win[5];
    assign win7      = r_win[6];
    assign win8      = r_win[7];
    assign win9      = r_win[8];

endmodule : window_3x3_generator
`default_nettype wire

// File: tb/tb_window_3x3_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_3x3_generator
// Description : Self-checking bench for window_3x3_generator on a 5x4 frame
//               with a position-based reference model and a window scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_window_3x3_generator;

    localparam int DATA_W = 8;
    localparam int W      = 5;
    localparam int H      = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_pixel;
    logic              out_valid;
    logic              out_last;
    logic [DATA_W-1:0] win1, win2, win3, win4, win5, win6, win7, win8, win9;
    logic [71:0]       w_obs;

    window_3x3_generator #(
        .DATA_W     (DATA_W),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_last  (out_last),
        .win1      (win1),
        .win2      (win2),
        .win3      (win3),
        .win4      (win4),
        .win5      (win5),
        .win6      (win6),
        .win7      (win7),
        .win8      (win8),
        .win9      (win9)
    );

    assign w_obs = {win1, win2, win3, win4, win5, win6, win7, win8, win9};

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state
    logic [7:0]  img [H][W];
    int          mr = 0;
    int          mc = 0;
    logic [72:0] sb [$];
    logic [71:0] last_exp = '0;
    logic [71:0] first_obs = '0;
    logic [71:0] last_obs = '0;
    int          n_win = 0;
    int          win_mark = 0;
    logic [72:0] mon_e;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input at the falling edge and update the model
    task automatic drive(input logic v, input logic s, input logic [7:0] p);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_pixel = p;
        if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                sb.push_back({(mr == H-1 && mc == W-1),
                              img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                              img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                              img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]});
            end
            if (mc == W-1) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    // Pixels of one frame from (0,0) up to but excluding position stop
    task automatic frame(input int base, input bit gaps, input int stop);
        for (int k = 0; k < stop; k++) begin
            if (gaps) idle($urandom_range(0, 2));
            drive(1'b1, (k == 0), 8'(base + 5 * (k / W) + (k % W)));
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        last_exp = '0;
        mr       = 0;
        mc       = 0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_last", out_last, 0);
        check("async_rst_win", w_obs, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Output monitor: every cycle, a window is due exactly when the scoreboard holds one
    always @(posedge clk) begin
        #1;
        check("out_valid", out_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("window", w_obs, mon_e[71:0]);
            check("out_last", out_last, mon_e[72]);
            last_exp = mon_e[71:0];
            n_win++;
            if (n_win == win_mark + 1) first_obs = w_obs;
            last_obs = w_obs;
        end else begin
            check("win_hold", w_obs, last_exp);
            check("last_idle", out_last, 0);
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check("rst_release_win", w_obs, 0);

        // Continuous frame
        win_mark = n_win;
        frame(0, 1'b0, W * H);
        idle(3);
        check("t1_count", n_win - win_mark, 6);
        check("t1_first", first_obs, {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});
        check("t1_lastwin", last_obs, {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19});

        // Same frame with random gaps
        win_mark = n_win;
        frame(0, 1'b1, W * H);
        idle(3);
        check("t2_count", n_win - win_mark, 6);
        check("t2_first", first_obs, {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});

        // Two back-to-back frames
        win_mark = n_win + 6;
        frame(0, 1'b0, W * H);
        frame(100, 1'b0, W * H);
        idle(3);
        check("t3_count", n_win - win_mark + 6, 12);
        check("t3_first2", first_obs, {8'd100, 8'd101, 8'd102, 8'd105, 8'd106, 8'd107, 8'd110, 8'd111, 8'd112});

        // Resync: sof at position (2,3), then a clean frame
        win_mark = n_win + 1;
        frame(0, 1'b0, 2 * W + 3);
        drive(1'b1, 1'b1, 8'd99);
        frame(0, 1'b0, W * H);
        idle(3);
        check("t4_count", n_win - win_mark + 1, 7);
        check("t4_first", first_obs, {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});

        // Reset pulse mid-row 2, then a fresh frame
        frame(50, 1'b0, 2 * W + 4);
        reset_pulse();
        win_mark = n_win;
        frame(0, 1'b0, W * H);
        idle(3);
        check("t5_count", n_win - win_mark, 6);
        check("t5_first", first_obs, {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_window_3x3_generator
`default_nettype wire
